// File: rtl/qs_srt_stack_arb.sv
// ----------------------------------------------------------------------------
// qs_srt_stack_arb
//   Round-robin arbiter and sequencer. It lets R sort requesters share one
//   qs_srt_stack instance.
//   - At most one stack command is issued per cycle. The grant is
//     combinational from req_vld.
//   - A clear request takes priority over all push/pop traffic.
//   - Each granted command is tracked through a POP_LAT-deep in-flight pipe.
//     Exactly one response, tagged with the requester id, comes back
//     POP_LAT cycles after the grant.
//
// Parameters
//   R        number of requesters (>= 2)
//   W        stack word width
//   POP_LAT  cycles from command issue to valid stk_head (response latency)
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_vld[R]      per-requester command valid
//   req_push[R]     1 = push, 0 = pop
//   req_dat[R*W]    push data, requester i at [i*W +: W]
//   req_gnt[R]      one-hot grant (command accepted this cycle)
//   rsp_vld[R]      one-hot response valid
//   rsp_err         response is an error (pop-empty / push-full)
//   rsp_dat[W]      pop data (0 for push responses and errors)
//   clr_req         request a stack clear
//   clr_ack         a clear is issued this cycle
//   stk_cmd_vld     stack command valid
//   stk_cmd_push    stack command is a push
//   stk_cmd_dat[W]  stack push data
//   stk_cmd_clr     stack clear
//   stk_cmd_err     stack error flag for the command issued this cycle
//   stk_head[W]     stack head register
//
// Optional build macro QS_SRT_STACK_ARB_STATS_EN adds three 16-bit
// saturating counters. clr_ack zeroes all of them.
//   stat_cmd    number of grants
//   stat_err    number of error responses
//   stat_stall  cycles with some req_vld high but no grant
// ----------------------------------------------------------------------------
module qs_srt_stack_arb #(
  parameter int R       = 2,
  parameter int W       = 32,
  parameter int POP_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_vld,
  input  logic [R-1:0]   req_push,
  input  logic [R*W-1:0] req_dat,
  output logic [R-1:0]   req_gnt,
  output logic [R-1:0]   rsp_vld,
  output logic           rsp_err,
  output logic [W-1:0]   rsp_dat,
  input  logic           clr_req,
  output logic           clr_ack,
  output logic           stk_cmd_vld,
  output logic           stk_cmd_push,
  output logic [W-1:0]   stk_cmd_dat,
  output logic           stk_cmd_clr,
  input  logic           stk_cmd_err,
  input  logic [W-1:0]   stk_head
`ifdef QS_SRT_STACK_ARB_STATS_EN
  ,
  output logic [15:0]    stat_cmd,
  output logic [15:0]    stat_err,
  output logic [15:0]    stat_stall
`endif
);

  localparam int IW   = (R > 1) ? $clog2(R) : 1;
  localparam int LAST = POP_LAT - 1;

  // --------------------------------------------------------------------------
  // Round-robin arbitration
  // --------------------------------------------------------------------------
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt_idx;
  logic          gnt_found;
  logic          gnt_any;

  // Scan starts one past the last winner and wraps R-1 -> 0. Because of this,
  // the most recent winner is considered last.
  // NOTE: every always_comb output gets a default before any conditional
  // logic. Otherwise a path that skips the assignment infers a latch.
  always_comb begin
    int c;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    c         = 0;
    for (int k = 1; k <= R; k++) begin
      c = int'(rr_ptr) + k;
      if (c >= R) c = c - R;
      if (!gnt_found && req_vld[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(c);
      end
    end
  end

  // A clear blocks all grants in its cycle.
  assign gnt_any = gnt_found && !clr_req;

  always_comb begin
    req_gnt = '0;
    if (gnt_any) req_gnt[gnt_idx] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Stack command issue
  // --------------------------------------------------------------------------
  assign clr_ack      = clr_req;
  assign stk_cmd_clr  = clr_req;
  assign stk_cmd_vld  = gnt_any;
  assign stk_cmd_push = gnt_any ? req_push[gnt_idx] : 1'b0;
  assign stk_cmd_dat  = gnt_any ? req_dat[int'(gnt_idx)*W +: W] : '0;

  // The pointer moves only on a real grant. Idle cycles and clear cycles
  // keep the current fairness order.
  // NOTE: sequential state uses non-blocking assignments only. Every
  // register therefore samples pre-edge values, regardless of the order of
  // the blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IW'(R - 1);
    end else if (gnt_any) begin
      rr_ptr <= gnt_idx;
    end
  end

  // --------------------------------------------------------------------------
  // In-flight pipe: {vld, id, push, err}. It advances every cycle.
  // --------------------------------------------------------------------------
  logic [POP_LAT-1:0] pipe_vld;
  logic [POP_LAT-1:0] pipe_push;
  logic [POP_LAT-1:0] pipe_err;
  logic [IW-1:0]      pipe_id [POP_LAT];

  // NOTE: this small array is reset on purpose. Responses still pending when
  // reset arrives must be dropped, so every stage has to come up invalid.
  // Large data memories would normally be left without a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld  <= '0;
      pipe_push <= '0;
      pipe_err  <= '0;
      for (int s = 0; s < POP_LAT; s++) pipe_id[s] <= '0;
    end else begin
      // The stack reports its error in the issue cycle, so it is captured
      // here together with the grant.
      pipe_vld[0]  <= gnt_any;
      pipe_id[0]   <= gnt_idx;
      pipe_push[0] <= stk_cmd_push;
      pipe_err[0]  <= gnt_any & stk_cmd_err;
      for (int s = 1; s < POP_LAT; s++) begin
        pipe_vld[s]  <= pipe_vld[s-1];
        pipe_id[s]   <= pipe_id[s-1];
        pipe_push[s] <= pipe_push[s-1];
        pipe_err[s]  <= pipe_err[s-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response. stk_head is valid exactly when the last stage is valid.
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_vld = '0;
    if (pipe_vld[LAST]) rsp_vld[pipe_id[LAST]] = 1'b1;
  end

  assign rsp_err = pipe_vld[LAST] & pipe_err[LAST];
  assign rsp_dat = (pipe_vld[LAST] && !pipe_push[LAST] && !pipe_err[LAST]) ?
                   stk_head : '0;

`ifdef QS_SRT_STACK_ARB_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating statistics counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cmd   <= '0;
      stat_err   <= '0;
      stat_stall <= '0;
    end else if (clr_ack) begin
      stat_cmd   <= '0;
      stat_err   <= '0;
      stat_stall <= '0;
    end else begin
      if (gnt_any && stat_cmd != 16'hFFFF)
        stat_cmd <= stat_cmd + 16'd1;
      if (rsp_err && stat_err != 16'hFFFF)
        stat_err <= stat_err + 16'd1;
      if ((|req_vld) && !gnt_any && stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qs_srt_stack_arb.sv
// ----------------------------------------------------------------------------
// tb_qs_srt_stack_arb
//   Directed-vector bench for qs_srt_stack_arb with R=2, W=32, POP_LAT=2.
//   A small behavioural 4-deep stack stands in for qs_srt_stack.
//   - cmd_err is combinational.
//   - A popped word shows up on stk_head two edges after issue.
//   Each vector row holds the inputs for one cycle and the hand-derived
//   grant, clear and response outputs for that same cycle.
// ----------------------------------------------------------------------------
module tb_qs_srt_stack_arb;

  localparam int R     = 2;
  localparam int W     = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_vld;
  logic [R-1:0]   req_push;
  logic [R*W-1:0] req_dat;
  logic [R-1:0]   req_gnt;
  logic [R-1:0]   rsp_vld;
  logic           rsp_err;
  logic [W-1:0]   rsp_dat;
  logic           clr_req;
  logic           clr_ack;
  logic           stk_cmd_vld;
  logic           stk_cmd_push;
  logic [W-1:0]   stk_cmd_dat;
  logic           stk_cmd_clr;
  logic           stk_cmd_err;
  logic [W-1:0]   stk_head;
`ifdef QS_SRT_STACK_ARB_STATS_EN
  logic [15:0]    stat_cmd, stat_err, stat_stall;
`endif

  always #5 clk = ~clk;

  qs_srt_stack_arb #(.R(R), .W(W), .POP_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_push     (req_push),
    .req_dat      (req_dat),
    .req_gnt      (req_gnt),
    .rsp_vld      (rsp_vld),
    .rsp_err      (rsp_err),
    .rsp_dat      (rsp_dat),
    .clr_req      (clr_req),
    .clr_ack      (clr_ack),
    .stk_cmd_vld  (stk_cmd_vld),
    .stk_cmd_push (stk_cmd_push),
    .stk_cmd_dat  (stk_cmd_dat),
    .stk_cmd_clr  (stk_cmd_clr),
    .stk_cmd_err  (stk_cmd_err),
    .stk_head     (stk_head)
`ifdef QS_SRT_STACK_ARB_STATS_EN
    ,
    .stat_cmd     (stat_cmd),
    .stat_err     (stat_err),
    .stat_stall   (stat_stall)
`endif
  );

  // --------------------------------------------------------------------------
  // Behavioural stack model
  // --------------------------------------------------------------------------
  logic [W-1:0] mem [DEPTH];
  int           sp;
  logic [W-1:0] head_d1;

  assign stk_cmd_err = stk_cmd_vld && (stk_cmd_push ? (sp == DEPTH) : (sp == 0));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp       <= 0;
      head_d1  <= '0;
      stk_head <= '0;
    end else begin
      stk_head <= head_d1;
      if (stk_cmd_clr) begin
        sp <= 0;
      end else if (stk_cmd_vld) begin
        if (stk_cmd_err) begin
          head_d1 <= 32'hDEAD_BEEF;  // garbage that the DUT must mask
        end else if (stk_cmd_push) begin
          mem[sp] <= stk_cmd_dat;
          sp      <= sp + 1;
        end else begin
          head_d1 <= mem[sp-1];
          sp      <= sp - 1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic         clr;
    logic [1:0]   vld;
    logic [1:0]   push;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   e_gnt;
    logic         e_ack;
    logic [1:0]   e_rsp;
    logic         e_err;
    logic [W-1:0] e_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic clr, input logic [1:0] vld, input logic [1:0] push,
                              input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [1:0] e_gnt, input logic e_ack,
                              input logic [1:0] e_rsp, input logic e_err,
                              input logic [W-1:0] e_dat);
    vec_t v;
    v.clr = clr; v.vld = vld; v.push = push; v.d0 = d0; v.d1 = d1;
    v.e_gnt = e_gnt; v.e_ack = e_ack; v.e_rsp = e_rsp; v.e_err = e_err; v.e_dat = e_dat;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req  = 1'b0;
    req_vld  = '0;
    req_push = '0;
    req_dat  = '0;
  endtask

  // Apply each row just after a rising edge, check it mid-cycle, then step.
  task automatic run_vecs(input string phase);
    logic         e_push;
    logic [W-1:0] e_cdat;
    for (int i = 0; i < vecs.size(); i++) begin
      clr_req  = vecs[i].clr;
      req_vld  = vecs[i].vld;
      req_push = vecs[i].push;
      req_dat  = {vecs[i].d1, vecs[i].d0};
      e_push   = vecs[i].e_gnt[0] ? vecs[i].push[0] : vecs[i].e_gnt[1] ? vecs[i].push[1] : 1'b0;
      e_cdat   = vecs[i].e_gnt[0] ? vecs[i].d0 : vecs[i].e_gnt[1] ? vecs[i].d1 : '0;
      #2;
      check($sformatf("%s%0d.gnt", phase, i),     64'(req_gnt),      64'(vecs[i].e_gnt));
      check($sformatf("%s%0d.ack", phase, i),     64'(clr_ack),      64'(vecs[i].e_ack));
      check($sformatf("%s%0d.cmd_clr", phase, i), 64'(stk_cmd_clr),  64'(vecs[i].e_ack));
      check($sformatf("%s%0d.cmd_vld", phase, i), 64'(stk_cmd_vld),  64'(|vecs[i].e_gnt));
      check($sformatf("%s%0d.cmd_push", phase, i),64'(stk_cmd_push), 64'(e_push));
      check($sformatf("%s%0d.cmd_dat", phase, i), 64'(stk_cmd_dat),  64'(e_cdat));
      check($sformatf("%s%0d.rsp_vld", phase, i), 64'(rsp_vld),      64'(vecs[i].e_rsp));
      check($sformatf("%s%0d.rsp_err", phase, i), 64'(rsp_err),      64'(vecs[i].e_err));
      check($sformatf("%s%0d.rsp_dat", phase, i), 64'(rsp_dat),      64'(vecs[i].e_dat));
      tick();
    end
    vecs.delete();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #23;
    check("rst.gnt",     64'(req_gnt),     64'h0);
    check("rst.rsp_vld", 64'(rsp_vld),     64'h0);
    check("rst.rsp_err", 64'(rsp_err),     64'h0);
    check("rst.rsp_dat", 64'(rsp_dat),     64'h0);
    check("rst.cmd_vld", 64'(stk_cmd_vld), 64'h0);
    check("rst.ack",     64'(clr_ack),     64'h0);
`ifdef QS_SRT_STACK_ARB_STATS_EN
    check("rst.stat_cmd",   64'(stat_cmd),   64'h0);
    check("rst.stat_err",   64'(stat_err),   64'h0);
    check("rst.stat_stall", 64'(stat_stall), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    //   clr  vld    push   d0         d1         gnt    ack  rsp    err  dat
    // Push from req0, then pop from req1 returns the pushed word.
    add(0, 2'b01, 2'b01, 32'hA,     32'h0,     2'b01, 0, 2'b00, 0, 32'h0);    // v0
    add(0, 2'b10, 2'b00, 32'h0,     32'h0,     2'b10, 0, 2'b00, 0, 32'h0);    // v1
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b01, 0, 32'h0);    // v2
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b10, 0, 32'hA);    // v3
    // Both requesters push for 6 cycles: grants alternate; 5th/6th overflow.
    add(0, 2'b11, 2'b11, 32'h100,   32'h101,   2'b01, 0, 2'b00, 0, 32'h0);    // v4
    add(0, 2'b11, 2'b11, 32'h102,   32'h101,   2'b10, 0, 2'b00, 0, 32'h0);    // v5
    add(0, 2'b11, 2'b11, 32'h102,   32'h103,   2'b01, 0, 2'b01, 0, 32'h0);    // v6
    add(0, 2'b11, 2'b11, 32'h104,   32'h103,   2'b10, 0, 2'b10, 0, 32'h0);    // v7
    add(0, 2'b11, 2'b11, 32'h104,   32'h105,   2'b01, 0, 2'b01, 0, 32'h0);    // v8
    add(0, 2'b11, 2'b11, 32'h106,   32'h105,   2'b10, 0, 2'b10, 0, 32'h0);    // v9
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b01, 1, 32'h0);    // v10
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b10, 1, 32'h0);    // v11
    // Five back-to-back pops: LIFO data, then pop-on-empty error.
    add(0, 2'b01, 2'b00, 32'h0,     32'h0,     2'b01, 0, 2'b00, 0, 32'h0);    // v12
    add(0, 2'b01, 2'b00, 32'h0,     32'h0,     2'b01, 0, 2'b00, 0, 32'h0);    // v13
    add(0, 2'b01, 2'b00, 32'h0,     32'h0,     2'b01, 0, 2'b01, 0, 32'h103);  // v14
    add(0, 2'b01, 2'b00, 32'h0,     32'h0,     2'b01, 0, 2'b01, 0, 32'h102);  // v15
    add(0, 2'b01, 2'b00, 32'h0,     32'h0,     2'b01, 0, 2'b01, 0, 32'h101);  // v16
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b01, 0, 32'h100);  // v17
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b01, 1, 32'h0);    // v18
    // Clear with req0 pending: clear wins, req0 next cycle, pop finds empty.
    add(0, 2'b10, 2'b10, 32'h0,     32'h55,    2'b10, 0, 2'b00, 0, 32'h0);    // v19
    add(1, 2'b01, 2'b00, 32'h0,     32'h0,     2'b00, 1, 2'b00, 0, 32'h0);    // v20
    add(0, 2'b01, 2'b00, 32'h0,     32'h0,     2'b01, 0, 2'b10, 0, 32'h0);    // v21
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b00, 0, 32'h0);    // v22
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b01, 1, 32'h0);    // v23
    // Clear held 3 cycles starves both requesters; pointer unchanged.
    add(1, 2'b11, 2'b11, 32'h77,    32'h88,    2'b00, 1, 2'b00, 0, 32'h0);    // v24
    add(1, 2'b11, 2'b11, 32'h77,    32'h88,    2'b00, 1, 2'b00, 0, 32'h0);    // v25
    add(1, 2'b11, 2'b11, 32'h77,    32'h88,    2'b00, 1, 2'b00, 0, 32'h0);    // v26
    add(0, 2'b11, 2'b11, 32'h77,    32'h88,    2'b10, 0, 2'b00, 0, 32'h0);    // v27
    add(0, 2'b01, 2'b01, 32'h77,    32'h0,     2'b01, 0, 2'b00, 0, 32'h0);    // v28
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b10, 0, 32'h0);    // v29
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b01, 0, 32'h0);    // v30
    // Two pops put in flight just before reset.
    add(0, 2'b10, 2'b00, 32'h0,     32'h0,     2'b10, 0, 2'b00, 0, 32'h0);    // v31
    add(0, 2'b01, 2'b00, 32'h0,     32'h0,     2'b01, 0, 2'b00, 0, 32'h0);    // v32
    run_vecs("v");

    // Asynchronous reset with two commands in flight.
    idle_inputs();
    rst_n = 1'b0;
    #2;
    check("arst.rsp_vld", 64'(rsp_vld), 64'h0);
    tick();
    rst_n = 1'b1;

    // In-flight responses are dropped; the pointer returns to R-1.
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b00, 0, 32'h0);    // p0
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b00, 0, 32'h0);    // p1
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b00, 0, 32'h0);    // p2
    add(0, 2'b11, 2'b11, 32'h1,     32'h2,     2'b01, 0, 2'b00, 0, 32'h0);    // p3
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b00, 0, 32'h0);    // p4
    add(0, 2'b00, 2'b00, 32'h0,     32'h0,     2'b00, 0, 2'b01, 0, 32'h0);    // p5
    run_vecs("p");
`ifdef QS_SRT_STACK_ARB_STATS_EN
    check("p.stat_cmd", 64'(stat_cmd), 64'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
